sr_pulse_driver: RTL and testbench
==================================

Name: sr_pulse_driver

Overview:
- Drives the set/reset inputs of an external SR latch from a valid/ready level-request interface. It is the command side of the latch's S/R interface.
- Converts each requested output level into a single timed S or R pulse of fixed width, followed by a dead time. S and R are never asserted together, so the latch's forbidden S=R=1 input state can never be driven.
- After each pulse, samples the latch's q output and compares it against an internal shadow of the expected state. A mismatch raises a sticky error flag.

Parameters:
- PULSE_W, 2: cycles S or R is held high per command; legal range 1..15.
- DEAD_W, 1: cycles with S=R=0 after each pulse, before the check; legal range 1..15.
- CW, 4: width of the internal phase counter; must satisfy 2^CW > max(PULSE_W, DEAD_W).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command.
- req_level  in  1  requested latch level (1 = set, 0 = reset).
- req_force  in  1  pulse even if req_level equals the shadow state.
- s_out  out  1  latch S drive, registered.
- r_out  out  1  latch R drive, registered.
- q_in  in  1  latch q feedback, synchronous to clk.
- shadow_q  out  1  expected latch state.
- busy  out  1  pulse sequence in progress (equals ~req_ready).
- err  out  1  sticky q mismatch flag.
- err_clr  in  1  clears err.
- pulse_cnt  out  8  number of pulses issued, wraps.

Behaviour:
- Reset (synchronous) forces:
  - state IDLE;
  - s_out=0, r_out=0, shadow_q=0, err=0, pulse_cnt=0;
  - req_ready=1, busy=0.
- States: IDLE, PULSE, DEAD, CHECK.
- Accept condition: req_valid && req_ready, sampled at a rising edge. req_ready=1 only in IDLE.
- IDLE, on accept:
  - If req_level==shadow_q and req_force=0: no-op. Stay in IDLE, no pulse, pulse_cnt unchanged, req_ready stays 1.
  - Otherwise: shadow_q<=req_level, pulse_cnt<=pulse_cnt+1 (255 wraps to 0), phase counter<=0, go to PULSE. s_out<=req_level and r_out<=~req_level at the same edge.
- PULSE: the selected output stays high for exactly PULSE_W cycles after the accept edge. On the last cycle, s_out and r_out go to 0 and the FSM moves to DEAD.
- DEAD: both outputs low for exactly DEAD_W cycles, then move to CHECK.
- CHECK: one cycle. At its edge, q_in is compared with shadow_q; a mismatch sets err. Then return to IDLE.
- Busy duration: req_ready is low for PULSE_W+DEAD_W+1 cycles per pulsed command. Back-to-back commands are accepted on the first IDLE cycle.
- Invariant: s_out & r_out == 0 in every cycle, including reset and the reset release.
- err_clr clears err at the next edge. If a CHECK mismatch occurs in the same cycle as err_clr, set wins and err=1.
- Reset mid-sequence: outputs drop to 0 at that edge, the sequence is abandoned, shadow_q=0. No cleanup pulse is issued.
- req_level and req_force are ignored when no accept occurs. Inputs changing during busy have no effect.
- Forced command at equal level: pulses normally. shadow_q is unchanged in value but is still re-written.

Test Plan:
1. PULSE_W=2, DEAD_W=1; release reset, req_level=1 accepted at edge E0 -> s_out=1 for 2 cycles, r_out=0 throughout, 1 dead cycle, 1 check cycle. req_ready returns high 4 cycles after E0; shadow_q=1, pulse_cnt=1.
2. With shadow_q=1: request req_level=1, req_force=0 -> no pulse, req_ready stays 1, pulse_cnt unchanged. Same request with req_force=1 -> a 2-cycle s_out pulse and pulse_cnt+1.
3. Request level 0 while q_in is held at 1 through CHECK -> r_out 2-cycle pulse, then err=1. err_clr for one cycle -> err=0. err_clr asserted in the same cycle as a new mismatch -> err stays 1.
4. Alternating 0/1 requests with req_valid held high for 300 commands -> s_out&r_out never both 1; each command is accepted on the first IDLE cycle; pulse_cnt wraps 255 to 0 and reads 44 at the end.
5. Assert reset in the second PULSE cycle -> next edge gives s_out=r_out=0, shadow_q=0, req_ready=1, err=0, pulse_cnt=0. The following request is handled normally.
6. PULSE_W=1, DEAD_W=15 build -> 1-cycle pulse, 15 dead cycles, busy for exactly 17 cycles.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// Command side of an external SR latch: turns level requests into one timed S or R pulse,
// waits out a dead time, then checks the latch q against the expected (shadow) state.
module sr_pulse_driver #(
    parameter int PULSE_W = 2,
    parameter int DEAD_W  = 1,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_level,
    input  logic       req_force,
    output logic       s_out,
    output logic       r_out,
    input  logic       q_in,
    output logic       shadow_q,
    output logic       busy,
    output logic       err,
    input  logic       err_clr,
    output logic [7:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, PULSE, DEAD, CHECK} state_t;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_W - 1);
    localparam logic [CW-1:0] PHASE_ONE  = CW'(1);

    state_t        state_q;
    logic [CW-1:0] phase_q;
    logic          s_q;
    logic          r_q;
    logic          level_q;
    logic          err_q;
    logic [7:0]    cnt_q;

    // s_q and r_q are only ever raised as complements at accept and cleared together,
    // so the forbidden S=R=1 latch input can never appear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            level_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid && (req_force || (req_level != level_q))) begin
                        level_q <= req_level;
                        cnt_q   <= cnt_q + 8'd1;
                        phase_q <= '0;
                        s_q     <= req_level;
                        r_q     <= ~req_level;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (phase_q == PULSE_LAST) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        phase_q <= '0;
                        state_q <= DEAD;
                    end else begin
                        phase_q <= phase_q + PHASE_ONE;
                    end
                end
                DEAD: begin
                    if (phase_q == DEAD_LAST) begin
                        phase_q <= '0;
                        state_q <= CHECK;
                    end else begin
                        phase_q <= phase_q + PHASE_ONE;
                    end
                end
                CHECK: begin
                    // Placed after the clear so a mismatch in the same cycle wins.
                    if (q_in != level_q) begin
                        err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign shadow_q  = level_q;
    assign err       = err_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Self-checking bench for sr_pulse_driver: scenario tasks plus randomized commands checked
// against a command-level timeline model (pulse for PULSE_W cycles, DEAD_W dead, one check).
module tb_sr_pulse_driver;

    localparam int P = 2;
    localparam int D = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       reqValid, reqLevel, reqForce, qIn, errClr;
    logic       reqReady, sOut, rOut, shadowQ, busy, err;
    logic [7:0] pulseCnt;

    logic       reqValid6, reqLevel6, reqForce6, qIn6, errClr6;
    logic       reqReady6, sOut6, rOut6, shadowQ6, busy6, err6;
    logic [7:0] pulseCnt6;

    int errors = 0;
    int checks = 0;
    logic monEn = 1'b0;

    logic       mShadow;
    logic       mErr;
    logic [7:0] mCnt;

    sr_pulse_driver #(.PULSE_W(P), .DEAD_W(D), .CW(4)) dut (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
        .req_level(reqLevel), .req_force(reqForce), .s_out(sOut), .r_out(rOut),
        .q_in(qIn), .shadow_q(shadowQ), .busy(busy), .err(err),
        .err_clr(errClr), .pulse_cnt(pulseCnt)
    );

    sr_pulse_driver #(.PULSE_W(1), .DEAD_W(15), .CW(4)) dut6 (
        .clk(clk), .reset(reset), .req_valid(reqValid6), .req_ready(reqReady6),
        .req_level(reqLevel6), .req_force(reqForce6), .s_out(sOut6), .r_out(rOut6),
        .q_in(qIn6), .shadow_q(shadowQ6), .busy(busy6), .err(err6),
        .err_clr(errClr6), .pulse_cnt(pulseCnt6)
    );

    always @(negedge clk) begin
        if (monEn) begin
            checks++;
            if (((sOut & rOut) !== 1'b0) || ((sOut6 & rOut6) !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL sr_overlap: got s=%b r=%b s6=%b r6=%b want no S&R", sOut, rOut, sOut6, rOut6);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] obs();
        return {reqReady, busy, sOut, rOut, shadowQ, err, pulseCnt};
    endfunction

    function automatic logic [13:0] expv(input logic rdy, input logic s, input logic r);
        return {rdy, ~rdy, s, r, mShadow, mErr, mCnt};
    endfunction

    task automatic model_reset();
        mShadow = 1'b0;
        mErr    = 1'b0;
        mCnt    = 8'd0;
    endtask

    // Drives one accept edge and advances the model; request fields are scrambled afterwards.
    task automatic drive_accept(input logic lvl, input logic frc, input logic clr, output logic pulsed);
        pulsed   = (lvl != mShadow) || frc;
        reqValid = 1'b1;
        reqLevel = lvl;
        reqForce = frc;
        errClr   = clr;
        tick();
        reqValid = 1'b0;
        errClr   = 1'b0;
        reqLevel = 1'($urandom);
        reqForce = 1'($urandom);
        if (clr) mErr = 1'b0;
        if (pulsed) begin
            mShadow = lvl;
            mCnt    = mCnt + 8'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqValid = 1'b0; reqLevel = 1'b0; reqForce = 1'b0; qIn = 1'b0; errClr = 1'b0;
        reqValid6 = 1'b0; reqLevel6 = 1'b0; reqForce6 = 1'b0; qIn6 = 1'b1; errClr6 = 1'b0;
        model_reset();
        tick();
        tick();
        monEn = 1'b1;
        checks++;
        if (obs() !== 14'b10_0000_0000_0000) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b want %b", obs(), 14'b10_0000_0000_0000);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want %b", obs(), expv(1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_basic_pulse();
        logic p;
        qIn = 1'b1;
        drive_accept(1'b1, 1'b0, 1'b0, p);
        for (int k = 0; k <= P + D; k++) begin
            checks++;
            if (obs() !== expv(1'b0, k < P, 1'b0)) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d: got %b want %b", k, obs(), expv(1'b0, k < P, 1'b0));
            end
            tick();
        end
        checks++;
        if ((obs() !== expv(1'b1, 1'b0, 1'b0)) || (pulseCnt !== 8'd1) || (shadowQ !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL basic_done: got %b want ready, shadow=1, cnt=1", obs());
        end
    endtask

    task automatic test_noop_and_force();
        logic p;
        qIn = 1'b1;
        drive_accept(1'b1, 1'b0, 1'b0, p);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("[TB] FAIL noop_cycle%0d: got %b want %b", k, obs(), expv(1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        drive_accept(1'b1, 1'b1, 1'b0, p);
        for (int k = 0; k <= P + D; k++) begin
            checks++;
            if (obs() !== expv(1'b0, k < P, 1'b0)) begin
                errors++;
                $display("[TB] FAIL force_cycle%0d: got %b want %b", k, obs(), expv(1'b0, k < P, 1'b0));
            end
            tick();
        end
        checks++;
        if ((obs() !== expv(1'b1, 1'b0, 1'b0)) || (pulseCnt !== 8'd2)) begin
            errors++;
            $display("[TB] FAIL force_done: got %b want cnt=2 ready", obs());
        end
    endtask

    task automatic test_err();
        logic p;
        qIn = 1'b1;
        drive_accept(1'b0, 1'b0, 1'b0, p);
        for (int k = 0; k <= P + D; k++) begin
            checks++;
            if (obs() !== expv(1'b0, 1'b0, k < P)) begin
                errors++;
                $display("[TB] FAIL errpulse_cycle%0d: got %b want %b", k, obs(), expv(1'b0, 1'b0, k < P));
            end
            tick();
        end
        mErr = 1'b1;
        checks++;
        if ((obs() !== expv(1'b1, 1'b0, 1'b0)) || (err !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL err_set: got %b want err=1", obs());
        end
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        mErr = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL err_clear: got %b want %b", obs(), expv(1'b1, 1'b0, 1'b0));
        end
        qIn = 1'b0;
        drive_accept(1'b1, 1'b1, 1'b0, p);
        for (int k = 0; k <= P + D; k++) begin
            if (k == P + D) errClr = 1'b1;
            tick();
        end
        errClr = 1'b0;
        mErr = 1'b1;
        checks++;
        if ((obs() !== expv(1'b1, 1'b0, 1'b0)) || (err !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL err_set_wins: got %b want err=1", obs());
        end
    endtask

    task automatic test_random_commands();
        logic p, lvl, frc, clr;
        for (int n = 0; n < 60; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                reqLevel = 1'($urandom);
                reqForce = 1'($urandom);
                tick();
            end
            lvl = 1'($urandom);
            frc = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 3) == 0);
            qIn = ($urandom_range(0, 3) == 0) ? ~lvl : lvl;
            drive_accept(lvl, frc, clr, p);
            if (p) begin
                for (int k = 0; k <= P + D; k++) begin
                    checks++;
                    if (obs() !== expv(1'b0, lvl & (k < P), ~lvl & (k < P))) begin
                        errors++;
                        $display("[TB] FAIL rand%0d_cycle%0d: got %b want %b", n, k, obs(),
                                 expv(1'b0, lvl & (k < P), ~lvl & (k < P)));
                    end
                    tick();
                end
                if (qIn != mShadow) mErr = 1'b1;
            end
            checks++;
            if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("[TB] FAIL rand%0d_end: got %b want %b", n, obs(), expv(1'b1, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic lvl;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        lvl = 1'b1;
        reqValid = 1'b1;
        reqForce = 1'b0;
        for (int n = 0; n < 300; n++) begin
            reqLevel = lvl;
            qIn = lvl;
            tick();
            mShadow = lvl;
            mCnt = mCnt + 8'd1;
            for (int k = 0; k <= P + D; k++) begin
                checks++;
                if (obs() !== expv(1'b0, lvl & (k < P), ~lvl & (k < P))) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_cycle%0d: got %b want %b", n, k, obs(),
                             expv(1'b0, lvl & (k < P), ~lvl & (k < P)));
                end
                reqLevel = 1'($urandom);
                reqForce = 1'($urandom);
                tick();
            end
            reqForce = 1'b0;
            checks++;
            if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("[TB] FAIL b2b%0d_idle: got %b want %b", n, obs(), expv(1'b1, 1'b0, 1'b0));
            end
            lvl = ~lvl;
        end
        reqValid = 1'b0;
        checks++;
        if (pulseCnt !== 8'd44) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d want 44", pulseCnt);
        end
    endtask

    task automatic test_reset_mid();
        logic p;
        qIn = 1'b1;
        drive_accept(~mShadow, 1'b0, 1'b0, p);
        tick();
        checks++;
        if ((sOut !== mShadow) || (rOut !== ~mShadow)) begin
            errors++;
            $display("[TB] FAIL mid_second_pulse: got s=%b r=%b want s=%b", sOut, rOut, mShadow);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if (obs() !== 14'b10_0000_0000_0000) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b want %b", obs(), 14'b10_0000_0000_0000);
        end
        drive_accept(1'b1, 1'b0, 1'b0, p);
        for (int k = 0; k <= P + D; k++) begin
            checks++;
            if (obs() !== expv(1'b0, k < P, 1'b0)) begin
                errors++;
                $display("[TB] FAIL after_reset_cycle%0d: got %b want %b", k, obs(), expv(1'b0, k < P, 1'b0));
            end
            tick();
        end
        checks++;
        if ((obs() !== expv(1'b1, 1'b0, 1'b0)) || (pulseCnt !== 8'd1)) begin
            errors++;
            $display("[TB] FAIL after_reset_done: got %b want cnt=1 ready", obs());
        end
    endtask

    task automatic test_long_dead();
        reqValid6 = 1'b1;
        reqLevel6 = 1'b1;
        qIn6 = 1'b1;
        tick();
        reqValid6 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            checks++;
            if ((busy6 !== 1'b1) || (sOut6 !== (k < 1)) || (rOut6 !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL long_cycle%0d: got busy=%b s=%b r=%b want busy=1 s=%b r=0",
                         k, busy6, sOut6, rOut6, (k < 1));
            end
            reqLevel6 = 1'($urandom);
            tick();
        end
        checks++;
        if ({busy6, reqReady6, sOut6, rOut6, shadowQ6, err6, pulseCnt6} !== {6'b010010, 8'd1}) begin
            errors++;
            $display("[TB] FAIL long_done: got %b want %b",
                     {busy6, reqReady6, sOut6, rOut6, shadowQ6, err6, pulseCnt6}, {6'b010010, 8'd1});
        end
    endtask

    initial begin
        $display("[TB] sr_pulse_driver bench start");
        test_reset();
        test_basic_pulse();
        test_noop_and_force();
        test_err();
        test_random_commands();
        test_back_to_back();
        test_reset_mid();
        test_long_dead();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
